// File: rtl/requant_pkg.sv
// rtl/requant_pkg.sv - shared widths, sat-flag vector type and signed clamp helper for the requantizer
package requant_pkg;

   localparam int DEF_IN_WIDTH  = 32;
   localparam int DEF_OUT_WIDTH = 8;
   localparam int DEF_SIZE      = 1;
   localparam int DEF_SHIFT_W   = 5;

   // Clamp arithmetic is done at a fixed wide width; IN_WIDTH+1 must not exceed it.
   localparam int MAX_W     = 64;
   localparam int MAX_LANES = 64;

   typedef logic [MAX_LANES-1:0] sat_vec_t;

   function automatic logic signed [MAX_W-1:0] clamp_signed(
      input logic signed [MAX_W-1:0] v,
      input int unsigned             ow
   );
      logic signed [MAX_W-1:0] hi;
      logic signed [MAX_W-1:0] lo;
      hi = $signed((MAX_W'(1) << (ow - 1)) - MAX_W'(1));
      lo = -$signed(MAX_W'(1) << (ow - 1));
      if (v > hi)
         clamp_signed = hi;
      else if (v < lo)
         clamp_signed = lo;
      else
         clamp_signed = v;
   endfunction

endpackage

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - one lane: round-half-up shift (stage 1 comb) and clamp (stage 2 comb)
// REQUANT_STATS_EN adds the per-lane sat output.
module requant_lane
   import requant_pkg::*;
#(
   parameter int IN_WIDTH  = DEF_IN_WIDTH,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH,
   parameter int SHIFT_W   = DEF_SHIFT_W
)(
   input  logic [IN_WIDTH-1:0]  x,
   input  logic [SHIFT_W-1:0]   shift_amt,
   output logic [IN_WIDTH:0]    r,
   input  logic [IN_WIDTH:0]    r_reg,
   output logic [OUT_WIDTH-1:0] pix
`ifdef REQUANT_STATS_EN
   ,
   output logic                 sat
`endif
);

   localparam logic [IN_WIDTH:0] ONE = (IN_WIDTH+1)'(1);

   logic signed [IN_WIDTH:0] t;
   logic signed [MAX_W-1:0]  wide;
   logic signed [MAX_W-1:0]  clamped;
   logic                     sat_flag;

   // One extra bit of headroom means the rounding bias can never wrap.
   always_comb begin
      t = $signed({x[IN_WIDTH-1], x});
      if (shift_amt != '0)
         t = t + $signed(ONE << (shift_amt - SHIFT_W'(1)));
      r = t >>> shift_amt;
   end

   always_comb begin
      wide     = MAX_W'($signed(r_reg));
      clamped  = clamp_signed(wide, OUT_WIDTH);
      pix      = clamped[OUT_WIDTH-1:0];
      sat_flag = (clamped != wide);
   end

`ifdef REQUANT_STATS_EN
   assign sat = sat_flag;
`else
   logic unused_sat;
   assign unused_sat = sat_flag;
`endif

endmodule

// File: rtl/requantize_stream.sv
// rtl/requantize_stream.sv - two-stage valid/ready requantizer: SIZE lanes, runtime shift, round, saturate
// REQUANT_STATS_EN adds the sticky 32-bit saturated-lane counter sat_count.
module requantize_stream
   import requant_pkg::*;
#(
   parameter int IN_WIDTH  = DEF_IN_WIDTH,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH,
   parameter int SIZE      = DEF_SIZE,
   parameter int SHIFT_W   = DEF_SHIFT_W
)(
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SHIFT_W-1:0]        shift_amt,
   input  logic [IN_WIDTH*SIZE-1:0]  pixel_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [OUT_WIDTH*SIZE-1:0] pixel_out
`ifdef REQUANT_STATS_EN
   ,
   output logic [31:0]               sat_count
`endif
);

   logic                               s1_valid;
   logic [SIZE-1:0][IN_WIDTH:0]        s1_r;
   logic [SIZE-1:0][IN_WIDTH:0]        r_comb;
   logic [OUT_WIDTH*SIZE-1:0]          pix_comb;
   logic                               s2_load;
`ifdef REQUANT_STATS_EN
   logic [SIZE-1:0]                    lane_sat;
`endif

   assign s2_load  = s1_valid && (!out_valid || out_ready);
   assign in_ready = !s1_valid || s2_load;

   for (genvar i = 0; i < SIZE; i++) begin : g_lane
      requant_lane #(
         .IN_WIDTH  (IN_WIDTH),
         .OUT_WIDTH (OUT_WIDTH),
         .SHIFT_W   (SHIFT_W)
      ) u_lane (
         .x         (pixel_in[IN_WIDTH*i +: IN_WIDTH]),
         .shift_amt (shift_amt),
         .r         (r_comb[i]),
         .r_reg     (s1_r[i]),
         .pix       (pix_comb[OUT_WIDTH*i +: OUT_WIDTH])
`ifdef REQUANT_STATS_EN
         ,
         .sat       (lane_sat[i])
`endif
      );
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_r     <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid)
            s1_r <= r_comb;
      end
   end

   // Output register: reloads on s2_load even while the current beat leaves, so no bubble.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         pixel_out <= '0;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         pixel_out <= pix_comb;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef REQUANT_STATS_EN
   sat_vec_t    sat_vec;
   logic [32:0] sat_sum;

   always_comb begin
      sat_vec           = '0;
      sat_vec[SIZE-1:0] = lane_sat;
      sat_sum           = {1'b0, sat_count};
      for (int i = 0; i < MAX_LANES; i++)
         sat_sum = sat_sum + 33'(sat_vec[i]);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         sat_count <= '0;
      else if (s2_load)
         sat_count <= sat_sum[32] ? 32'hFFFF_FFFF : sat_sum[31:0];
   end
`endif

endmodule

// File: tb/tb_requantize_stream.sv
// tb/tb_requantize_stream.sv - scoreboard bench for requantize_stream (2 lanes, 32->8 bits)
// REQUANT_STATS_EN enables the sat_count checks.
module tb_requantize_stream;

   localparam int IW = 32;
   localparam int OW = 8;
   localparam int SZ = 2;
   localparam int SW = 5;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [SW-1:0]     shift_amt = '0;
   logic [IW*SZ-1:0]  pixel_in = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [OW*SZ-1:0]  pixel_out;
`ifdef REQUANT_STATS_EN
   logic [31:0]       sat_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [OW*SZ-1:0] exp_q[$];
   longint           out_log[$];
   longint           model_sat = 0;
   logic             prev_hold = 1'b0;
   logic [OW*SZ-1:0] prev_pix  = '0;
   logic             saw_stall = 1'b0;

   always #5 clock = ~clock;

   requantize_stream #(
      .IN_WIDTH  (IW),
      .OUT_WIDTH (OW),
      .SIZE      (SZ),
      .SHIFT_W   (SW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .shift_amt (shift_amt),
      .pixel_in  (pixel_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pixel_out (pixel_out)
`ifdef REQUANT_STATS_EN
      ,
      .sat_count (sat_count)
`endif
   );

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Real-valued definition: floor((x + 2^(sh-1)) / 2^sh), then clamp to the output range.
   function automatic longint model_lane(input longint x, input int sh, output bit sat);
      longint d, num, q;
      d   = longint'(1) << sh;
      num = x + ((sh > 0) ? d / 2 : 0);
      q   = num / d;
      if ((num % d) != 0 && num < 0)
         q = q - 1;
      sat = 1'b0;
      if (q > 127) begin q = 127; sat = 1'b1; end
      if (q < -128) begin q = -128; sat = 1'b1; end
      return q;
   endfunction

   always @(negedge clock) begin
      if (!reset) begin
         exp_q.delete();
         model_sat = 0;
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", longint'(out_valid), 1);
            chk("hold_data", longint'(pixel_out), longint'(prev_pix));
         end
         if (in_valid && !in_ready)
            saw_stall = 1'b1;
         if (in_valid && in_ready) begin
            logic [OW*SZ-1:0] e;
            for (int l = 0; l < SZ; l++) begin
               bit     s;
               longint v;
               v = model_lane(longint'($signed(pixel_in[IW*l +: IW])), int'(shift_amt), s);
               e[OW*l +: OW] = OW'(v);
               if (s) model_sat++;
            end
            exp_q.push_back(e);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", longint'(pixel_out), -1);
            end else begin
               chk("scoreboard", longint'(pixel_out), longint'(exp_q.pop_front()));
            end
            out_log.push_back(longint'($signed(pixel_out[OW-1:0])));
         end
         prev_hold = out_valid && !out_ready;
         prev_pix  = pixel_out;
      end
   end

   task automatic send(input longint a, input longint b, input int sh);
      int n;
      in_valid  = 1'b1;
      pixel_in  = {IW'(b), IW'(a)};
      shift_amt = SW'(sh);
      n = 0;
      @(negedge clock);
      while (!in_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (n >= 50) chk("send_timeout", 0, 1);
      @(posedge clock);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 100) begin
         @(posedge clock);
         #1 n++;
      end
      if (n >= 100) chk("drain_timeout", 0, 1);
   endtask

   task automatic chk_log(input string name, input longint e[]);
      chk({name, "_count"}, out_log.size(), e.size());
      for (int i = 0; i < e.size() && i < out_log.size(); i++)
         chk(name, out_log[i], e[i]);
   endtask

   initial begin
      longint e2[] = '{2, 1, -1, -2, 0};
      longint e3[] = '{127, -128, 127};
      longint e4[] = '{0, 1, 2, 3, 4, 5, 6, 7};
      longint e5[] = '{127, 1, 16};
      int     lat;

      // Reset held with a beat offered.
      in_valid = 1'b1;
      pixel_in = {IW'(64'sd5), IW'(64'sd5)};
      repeat (3) @(posedge clock);
      #1;
      chk("rst_in_ready", longint'(in_ready), 1);
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_pixel_out", longint'(pixel_out), 0);
`ifdef REQUANT_STATS_EN
      chk("rst_sat_count", longint'(sat_count), 0);
`endif
      in_valid = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1;

      // Rounding at shift 4 (lane 1 carries the negated value).
      out_log.delete();
      foreach (e2[i]) begin
         longint xs[5] = '{24, 23, -24, -25, 0};
         send(xs[i], -xs[i], 4);
      end
      drain();
      chk_log("round", e2);

      // Pure saturation at shift 0.
      out_log.delete();
      send(200, -200, 0);
      send(-200, 200, 0);
      send(127, -127, 0);
      drain();
      chk_log("sat", e3);
`ifdef REQUANT_STATS_EN
      chk("sat_count_lit", longint'(sat_count), 4);
`endif

      // Back-pressure: out_ready low for four cycles mid-stream.
      out_log.delete();
      saw_stall = 1'b0;
      fork
         for (int i = 0; i < 8; i++) send(i * 16, -(i * 16), 4);
         begin
            repeat (3) @(posedge clock);
            #1 out_ready = 1'b0;
            repeat (4) @(posedge clock);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_in_ready_dropped", longint'(saw_stall), 1);
      chk_log("bp", e4);

      // Per-beat shift.
      out_log.delete();
      send(256, -256, 1);
      send(256, -256, 8);
      send(256, -256, 4);
      drain();
      chk_log("shift", e5);
`ifdef REQUANT_STATS_EN
      chk("sat_count_model", longint'(sat_count), model_sat);
`endif

      // Reset with two beats in flight, then latency of the next beat.
      out_ready = 1'b0;
      send(10, 20, 0);
      send(30, 40, 0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("mid_rst_out_valid", longint'(out_valid), 0);
      @(posedge clock);
      #1 reset = 1'b1;
      out_ready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      chk("post_rst_out_valid", longint'(out_valid), 0);
      out_log.delete();
      send(48, -48, 4);
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clock);
         #1 lat++;
      end
      chk("post_rst_latency", lat, 2);
      drain();
      chk("post_rst_count", out_log.size(), 1);
      if (out_log.size() > 0) chk("post_rst_value", out_log[0], 3);
`ifdef REQUANT_STATS_EN
      chk("post_rst_sat_count", longint'(sat_count), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
